alu_sequencer: RTL and testbench

Programmable initiator for the 8-bit ALU. It holds a small program of (opcode, immediate) pairs and, on `start`, issues each entry in order on the ALU's `selector`/`data_in`/`enable` inputs. After a fixed settle interval it captures the ALU result `Y`. It sits between the host/test logic and the ALU and drives its command side as the opposite end of that interface.

---
 rtl/alu_sequencer.sv | 147 ++++++++++++++
 tb/tb_alu_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Programmable initiator for the 8-bit ALU: replays a stored (opcode, immediate) program and captures Y.
// Optional build macro ALU_SEQ_ZERO_HALT_EN ends a run early when an intermediate result is zero.
module alu_sequencer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned SETTLE = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [3:0]                 wr_op,
    input  logic [7:0]                 wr_imm,
    input  logic [$clog2(DEPTH):0]     prog_len,
    input  logic                       start,
    input  logic [7:0]                 y_in,
    output logic [3:0]                 selector,
    output logic [7:0]                 data_in,
    output logic                       enable,
    output logic [7:0]                 result,
    output logic                       result_valid,
    output logic [$clog2(DEPTH)-1:0]   pc,
    output logic                       busy,
    output logic                       done,
    output logic                       halted
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t          state;
    logic [11:0]     mem [DEPTH];
    logic [AW:0]     len_q;
    logic [CW-1:0]   cnt_q;
    logic [AW:0]     start_len_c;
    logic [AW-1:0]   pc_next_c;
    logic            last_c;
    logic            halt_c;

    // Program store is not reset; host writes are only accepted between runs.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem[wr_addr] <= {wr_op, wr_imm};
        end
    end

    assign start_len_c = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
    assign pc_next_c   = pc + AW'(1);
    assign last_c      = ((AW+1)'(pc) + (AW+1)'(1)) == len_q;

`ifdef ALU_SEQ_ZERO_HALT_EN
    assign halt_c = (y_in == 8'h00) && !last_c;
`else
    assign halt_c = 1'b0;
    assign halted = 1'b0;
`endif

    // Sequencer: outputs are loaded on the edge that enters each state so they are valid in that state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            selector     <= '0;
            data_in      <= '0;
            enable       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            pc           <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef ALU_SEQ_ZERO_HALT_EN
            halted       <= 1'b0;
`endif
        end else begin
            enable       <= 1'b0;
            result_valid <= 1'b0;
            done         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q <= start_len_c;
                        pc    <= '0;
`ifdef ALU_SEQ_ZERO_HALT_EN
                        halted <= 1'b0;
`endif
                        if (start_len_c == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state               <= S_ISSUE;
                            busy                <= 1'b1;
                            enable              <= 1'b1;
                            {selector, data_in} <= mem[AW'(0)];
                        end
                    end
                end
                S_ISSUE: begin
                    cnt_q <= '0;
                    if (SETTLE == 0) begin
                        state <= S_CAPTURE;
                    end else begin
                        state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == CW'(SETTLE - 1)) begin
                        state <= S_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_CAPTURE: begin
                    result       <= y_in;
                    result_valid <= 1'b1;
                    if (last_c || halt_c) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
`ifdef ALU_SEQ_ZERO_HALT_EN
                        halted <= halt_c;
`endif
                    end else begin
                        state               <= S_ISSUE;
                        pc                  <= pc_next_c;
                        enable              <= 1'b1;
                        {selector, data_in} <= mem[pc_next_c];
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer (DEPTH=16, SETTLE=2, so P=4 cycles per instruction).
// Halt expectations follow ALU_SEQ_ZERO_HALT_EN when the bench is built with it.
module tb_alu_sequencer;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AW     = 4;
    localparam int unsigned SETTLE = 2;
    localparam int          MAXC   = 80;

    logic          clk;
    logic          reset_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_op;
    logic [7:0]    wr_imm;
    logic [AW:0]   prog_len;
    logic          start;
    logic [7:0]    y_in;
    logic [3:0]    selector;
    logic [7:0]    data_in;
    logic          enable;
    logic [7:0]    result;
    logic          result_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          halted;
    logic          pass_mode;

    int checks;
    int failures;

    logic          tr_en   [0:MAXC];
    logic          tr_rv   [0:MAXC];
    logic          tr_done [0:MAXC];
    logic          tr_busy [0:MAXC];
    logic          tr_halt [0:MAXC];
    logic [3:0]    tr_sel  [0:MAXC];
    logic [7:0]    tr_din  [0:MAXC];
    logic [7:0]    tr_res  [0:MAXC];
    logic [AW-1:0] tr_pc   [0:MAXC];

    alu_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_op(wr_op),
        .wr_imm(wr_imm), .prog_len(prog_len), .start(start), .y_in(y_in),
        .selector(selector), .data_in(data_in), .enable(enable), .result(result),
        .result_valid(result_valid), .pc(pc), .busy(busy), .done(done), .halted(halted)
    );

    // ALU stub: sum of operand and selector, or plain pass-through of the operand.
    assign y_in = pass_mode ? data_in : data_in + 8'(selector);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end 1 time unit after a rising edge.
    task automatic write_entry(input logic [AW-1:0] a, input logic [3:0] op, input logic [7:0] imm);
        wr_en = 1'b1; wr_addr = a; wr_op = op; wr_imm = imm;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic write_base_program();
        write_entry(4'd0, 4'hF, 8'h05);
        write_entry(4'd1, 4'hE, 8'h00);
        write_entry(4'd2, 4'hF, 8'h03);
    endtask

    // Cycle 0 is the current cycle (start high); records cycles 1..ncyc. Optionally injects start+write at cycle inj.
    task automatic run_trace(input logic [AW:0] len, input int ncyc, input int inj);
        prog_len = len;
        start    = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            wr_en = 1'b0;
            if (c == inj) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_op = 4'h0; wr_imm = 8'hAA;
            end
            tr_en[c] = enable;  tr_rv[c] = result_valid; tr_done[c] = done;
            tr_busy[c] = busy;  tr_halt[c] = halted;     tr_sel[c] = selector;
            tr_din[c] = data_in; tr_res[c] = result;     tr_pc[c] = pc;
        end
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] got;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got = {enable, result_valid, busy, done, halted, |selector, |data_in, |result, |pc};
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_out bit%0d got=%b exp=0", i, got[i]);
            end
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, enable} !== 3'b000) begin
            failures++;
            $display("FAIL reset_release busy/done/en got=%b exp=000", {busy, done, enable});
        end
    endtask

    task automatic test_three_run();
        logic [3:0] esel [3];
        logic [7:0] edin [3];
        logic [7:0] eres [3];
        int ic;
        esel[0] = 4'hF; esel[1] = 4'hE; esel[2] = 4'hF;
        edin[0] = 8'h05; edin[1] = 8'h00; edin[2] = 8'h03;
        eres[0] = 8'h14; eres[1] = 8'h0E; eres[2] = 8'h12;
        write_base_program();
        run_trace(5'd3, 16, 0);
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if ({tr_en[c], tr_rv[c], tr_done[c], tr_busy[c]} !==
                {(c == 1 || c == 5 || c == 9), (c == 5 || c == 9 || c == 13), (c == 13), (c <= 12)}) begin
                failures++;
                $display("FAIL three_run_ctrl c=%0d en/rv/done/busy got=%b%b%b%b", c,
                         tr_en[c], tr_rv[c], tr_done[c], tr_busy[c]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            ic = 1 + i * 4;
            checks++;
            if ({tr_sel[ic], tr_din[ic]} !== {esel[i], edin[i]}) begin
                failures++;
                $display("FAIL three_run_issue i=%0d got=%h/%h exp=%h/%h", i, tr_sel[ic], tr_din[ic], esel[i], edin[i]);
            end
            checks++;
            if (tr_res[ic + 4] !== eres[i]) begin
                failures++;
                $display("FAIL three_run_result i=%0d got=%h exp=%h", i, tr_res[ic + 4], eres[i]);
            end
        end
    endtask

    task automatic test_ignored();
        int ndone;
        run_trace(5'd3, 16, 3);
        ndone = 0;
        for (int c = 1; c <= 16; c++) ndone += int'(tr_done[c]);
        checks++;
        if (ndone != 1 || tr_done[13] !== 1'b1) begin
            failures++;
            $display("FAIL ignored_done count=%0d done13=%b exp=1/1", ndone, tr_done[13]);
        end
        run_trace(5'd1, 6, 0);
        checks++;
        if ({tr_sel[1], tr_din[1]} !== {4'hF, 8'h05}) begin
            failures++;
            $display("FAIL ignored_entry0 got=%h/%h exp=f/05", tr_sel[1], tr_din[1]);
        end
        checks++;
        if (tr_done[5] !== 1'b1) begin
            failures++;
            $display("FAIL ignored_rerun_done got=%b exp=1", tr_done[5]);
        end
    endtask

    task automatic test_len_zero();
        run_trace(5'd0, 5, 0);
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if ({tr_done[c], tr_en[c], tr_busy[c]} !== {(c == 1), 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL len_zero c=%0d done/en/busy got=%b%b%b", c, tr_done[c], tr_en[c], tr_busy[c]);
            end
        end
    endtask

    task automatic test_len_clamp();
        int nen;
        int ndone;
        for (int i = 0; i < 16; i++) write_entry(AW'(i), 4'h3, 8'(i * 3));
        run_trace(5'd20, 70, 0);
        nen = 0;
        ndone = 0;
        for (int c = 1; c <= 70; c++) begin
            nen += int'(tr_en[c]);
            ndone += int'(tr_done[c]);
        end
        checks++;
        if (nen != 16) begin
            failures++;
            $display("FAIL clamp_enables got=%0d exp=16", nen);
        end
        checks++;
        if (ndone != 1 || tr_done[65] !== 1'b1) begin
            failures++;
            $display("FAIL clamp_done count=%0d done65=%b exp=1/1", ndone, tr_done[65]);
        end
        checks++;
        if ({tr_sel[61], tr_din[61], tr_res[65], tr_pc[65]} !== {4'h3, 8'h2D, 8'h30, 4'hF}) begin
            failures++;
            $display("FAIL clamp_last sel/din/res/pc got=%h/%h/%h/%h exp=3/2d/30/f",
                     tr_sel[61], tr_din[61], tr_res[65], tr_pc[65]);
        end
        checks++;
        if ({tr_busy[64], tr_busy[65]} !== 2'b10) begin
            failures++;
            $display("FAIL clamp_busy_edge got=%b exp=10", {tr_busy[64], tr_busy[65]});
        end
    endtask

    task automatic test_reset_midrun();
        write_base_program();
        prog_len = 5'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({busy, pc} !== {1'b1, 4'd1}) begin
            failures++;
            $display("FAIL midrun_pre busy/pc got=%b/%0d exp=1/1", busy, pc);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({enable, busy, pc, result, selector} !== '0) begin
            failures++;
            $display("FAIL midrun_reset en/busy/pc/res/sel got=%b/%b/%0d/%h/%h", enable, busy, pc, result, selector);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL midrun_no_done c=%0d got=%b exp=0", c, done);
            end
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_trace(5'd3, 16, 0);
        checks++;
        if ({tr_en[1], tr_pc[1], tr_sel[1], tr_din[1]} !== {1'b1, 4'd0, 4'hF, 8'h05}) begin
            failures++;
            $display("FAIL midrun_restart en/pc/sel/din got=%b/%0d/%h/%h", tr_en[1], tr_pc[1], tr_sel[1], tr_din[1]);
        end
        checks++;
        if (tr_done[13] !== 1'b1) begin
            failures++;
            $display("FAIL midrun_restart_done got=%b exp=1", tr_done[13]);
        end
    endtask

    task automatic test_zero_halt();
        int nen;
        pass_mode = 1'b1;
        run_trace(5'd3, 16, 0);
        pass_mode = 1'b0;
        nen = 0;
        for (int c = 1; c <= 16; c++) nen += int'(tr_en[c]);
`ifdef ALU_SEQ_ZERO_HALT_EN
        checks++;
        if ({tr_done[9], tr_halt[9], tr_pc[9], tr_res[9], tr_done[13]} !== {1'b1, 1'b1, 4'd1, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL halt_stop done9/halt9/pc9/res9/done13 got=%b/%b/%0d/%h/%b",
                     tr_done[9], tr_halt[9], tr_pc[9], tr_res[9], tr_done[13]);
        end
        checks++;
        if (nen != 2 || tr_halt[14] !== 1'b1) begin
            failures++;
            $display("FAIL halt_enables_hold en=%0d halt14=%b exp=2/1", nen, tr_halt[14]);
        end
`else
        checks++;
        if ({tr_done[9], tr_done[13], tr_res[13]} !== {1'b0, 1'b1, 8'h03}) begin
            failures++;
            $display("FAIL nohalt_run done9/done13/res13 got=%b/%b/%h exp=0/1/03", tr_done[9], tr_done[13], tr_res[13]);
        end
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if (tr_halt[c] !== 1'b0) begin
                failures++;
                $display("FAIL nohalt_halted c=%0d got=%b exp=0", c, tr_halt[c]);
            end
        end
        checks++;
        if (nen != 3) begin
            failures++;
            $display("FAIL nohalt_enables got=%0d exp=3", nen);
        end
`endif
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        pass_mode = 1'b0;
        reset_n   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_op     = '0;
        wr_imm    = '0;
        prog_len  = '0;
        start     = 1'b0;
        test_reset();
        test_three_run();
        test_ignored();
        test_len_zero();
        test_len_clamp();
        test_reset_midrun();
        test_zero_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
